speed_cmd_scheduler: RTL and testbench
======================================

// Module: speed_cmd_scheduler
// PURPOSE
//  Sequences the playback-speed divider: merges push-button requests (with hold-to-repeat) and a
//  valid/ready command port into single-cycle speed_up/speed_down/speed_reset pulses for the divider.
//  Enforces one pulse per holdoff window and div_count saturation limits. Sits between input
//  synchronisers/command decoder and the speed divider; div_count is fed back from the divider.
// PARAMETERS
//  STEP          3            divider change per pulse (must match divider step)
//  MIN_DIV       32'd16       lowest div_count allowed after a speed_up
//  MAX_DIV       32'd65535    highest div_count allowed after a speed_down
//  REPEAT_DELAY  12_500_000   cycles a button is held before first auto-repeat (>=1)
//  REPEAT_RATE   2_500_000    cycles between auto-repeats (>=1)
//  HOLDOFF       4            idle cycles after a pulse before next issue (>=1)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  btn_up       in   1   synchronised level, faster (divider count down)
//  btn_down     in   1   synchronised level, slower (divider count up)
//  btn_rst      in   1   synchronised level, default speed
//  cmd_valid    in   1   command present
//  cmd_code     in   2   00 nop, 01 up, 10 down, 11 reset
//  cmd_ready    out  1   command accepted when cmd_valid & cmd_ready
//  div_count    in   32  current divider count, from the divider
//  speed_up     out  1   one-cycle pulse to divider
//  speed_down   out  1   one-cycle pulse to divider
//  speed_reset  out  1   one-cycle pulse to divider
//  sat_drop     out  1   one-cycle pulse: an up/down request was discarded by the limits
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready 0 during reset, 1 the cycle after; FSM IDLE, pending flags clear,
//   holdoff 0, round-robin pointer = button. Reset mid-operation discards all pending and timers.
//  Button FSM (IDLE, DELAY, REPEAT): IDLE: if any btn high, latch cur = highest priority held
//   (rst > up > down), raise button event, load timer REPEAT_DELAY-1, go DELAY.
//   DELAY: cur low -> IDLE; timer==0 -> event (not for rst: rst stays in DELAY until release), load
//   REPEAT_RATE-1, go REPEAT; else decrement. REPEAT: cur low -> IDLE; timer==0 -> event, reload.
//   Other buttons ignored while cur held. Button held through reset release fires on first cycle.
//  Pending: one-deep per source (pend_btn, pend_cmd, each with 2-bit code). Button event while
//   pend_btn set is dropped silently. cmd_ready = ~pend_cmd. Accepted nop is consumed, no pending.
//  Issue (combinational select, registered outputs), only when holdoff == 0:
//   - any pending reset wins: speed_reset next cycle, BOTH pending cleared.
//   - else both pending: source at rr pointer wins, rr flips to other source; loser stays pending.
//   - else the single pending source issues.
//   - up allowed iff div_count >= MIN_DIV + STEP; down allowed iff div_count + STEP <= MAX_DIV
//     (33-bit compare, no wrap). Disallowed: no pulse, sat_drop next cycle, pending cleared, holdoff unchanged.
//   - pulse issued: holdoff loaded HOLDOFF, decrements to 0; issue blocked while nonzero.
//  Latency: event/accept in cycle n -> pulse in cycle n+1 when holdoff==0 and uncontested.
//  At most one of speed_up/speed_down/speed_reset/sat_drop high in any cycle; each exactly 1 cycle.
// TESTING (REPEAT_DELAY=10, REPEAT_RATE=4, HOLDOFF=2, STEP=3, MIN_DIV=16, MAX_DIV=100, div model)
//  1 btn_up held 30 cycles from div_count=50 -> speed_up at +1, +11, +15, +19, +23, +27; 6 pulses, div 32.
//  2 cmd 01 and btn_down event same cycle, rr=button -> speed_down first, speed_up HOLDOFF+1 later; rr=cmd next.
//  3 cmd 10 pending, btn_rst pressed -> single speed_reset, pend_cmd cleared, cmd_ready high next cycle.
//  4 div_count=18, cmd 01 -> no speed_up, sat_drop 1 cycle; div_count=98, cmd 10 -> sat_drop.
//  5 cmd_valid held with 01 x3 back-to-back -> cmd_ready low while pending; pulses spaced 3 cycles.
//  6 reset asserted while DELAY/pending/holdoff active -> all outputs 0, no pulse after release until new input.

Source files
------------

// File: rtl/speed_cmd_scheduler.sv
// Speed command scheduler: merges held push-buttons (with auto-repeat) and a valid/ready
// command port into rate-limited, saturation-checked single-cycle divider pulses.
module speed_cmd_scheduler #(
    parameter int unsigned STEP         = 3,
    parameter logic [31:0] MIN_DIV      = 32'd16,
    parameter logic [31:0] MAX_DIV      = 32'd65535,
    parameter int unsigned REPEAT_DELAY = 12_500_000,
    parameter int unsigned REPEAT_RATE  = 2_500_000,
    parameter int unsigned HOLDOFF      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_rst,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_code,
    output logic        cmd_ready,
    input  logic [31:0] div_count,
    output logic        speed_up,
    output logic        speed_down,
    output logic        speed_reset,
    output logic        sat_drop
);
    localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int unsigned HO_W    = $clog2(HOLDOFF + 1);
    localparam int unsigned CMP_W   = 33;

    localparam logic [1:0] CODE_NOP  = 2'b00;
    localparam logic [1:0] CODE_UP   = 2'b01;
    localparam logic [1:0] CODE_DOWN = 2'b10;
    localparam logic [1:0] CODE_RST  = 2'b11;

    localparam logic [TMR_W-1:0] DELAY_LOAD = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RATE_LOAD  = TMR_W'(REPEAT_RATE - 1);
    localparam logic [HO_W-1:0]  HO_LOAD    = HO_W'(HOLDOFF);
    localparam logic [CMP_W-1:0] UP_FLOOR   = CMP_W'(MIN_DIV) + CMP_W'(STEP);
    localparam logic [CMP_W-1:0] DOWN_CEIL  = CMP_W'(MAX_DIV);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } btn_state_t;

    btn_state_t       state_q, state_d;
    logic [1:0]       cur_q, cur_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             cur_held;
    logic             btn_evt;
    logic [1:0]       evt_code;

    logic             pend_btn_q, pend_btn_d;
    logic [1:0]       pend_btn_code_q, pend_btn_code_d;
    logic             pend_cmd_q, pend_cmd_d;
    logic [1:0]       pend_cmd_code_q, pend_cmd_code_d;
    logic [HO_W-1:0]  hold_q, hold_d;
    logic             rr_cmd_q, rr_cmd_d;
    logic             up_d, down_d, rst_d, sat_d;

    logic             pb_v, pc_v, use_cmd, up_ok, down_ok;
    logic [1:0]       pb_c, pc_c, win_c;

    assign cur_held = (cur_q == CODE_RST) ? btn_rst :
                      (cur_q == CODE_UP)  ? btn_up  : btn_down;

    // Button sequencer: first press, hold delay, then periodic auto-repeat (reset never repeats)
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        tmr_d    = tmr_q;
        btn_evt  = 1'b0;
        evt_code = cur_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_rst | btn_up | btn_down) begin
                    cur_d    = btn_rst ? CODE_RST : (btn_up ? CODE_UP : CODE_DOWN);
                    evt_code = cur_d;
                    btn_evt  = 1'b1;
                    tmr_d    = DELAY_LOAD;
                    state_d  = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (!cur_held) begin
                    state_d = ST_IDLE;
                end else if (tmr_q == '0) begin
                    if (cur_q != CODE_RST) begin
                        btn_evt = 1'b1;
                        tmr_d   = RATE_LOAD;
                        state_d = ST_REPEAT;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_REPEAT: begin
                if (!cur_held) begin
                    state_d = ST_IDLE;
                end else if (tmr_q == '0) begin
                    btn_evt = 1'b1;
                    tmr_d   = RATE_LOAD;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Issue select: same-cycle events bypass the pending slots so an uncontested request pulses next cycle
    always_comb begin
        pb_v    = pend_btn_q | btn_evt;
        pb_c    = pend_btn_q ? pend_btn_code_q : evt_code;
        pc_v    = pend_cmd_q | (cmd_valid & cmd_ready & (cmd_code != CODE_NOP));
        pc_c    = pend_cmd_q ? pend_cmd_code_q : cmd_code;
        up_ok   = {1'b0, div_count} >= UP_FLOOR;
        down_ok = ({1'b0, div_count} + CMP_W'(STEP)) <= DOWN_CEIL;
        use_cmd = 1'b0;
        win_c   = CODE_NOP;

        pend_btn_d      = pb_v;
        pend_btn_code_d = pb_c;
        pend_cmd_d      = pc_v;
        pend_cmd_code_d = pc_c;
        rr_cmd_d        = rr_cmd_q;
        hold_d          = (hold_q != '0) ? hold_q - HO_W'(1) : hold_q;
        up_d            = 1'b0;
        down_d          = 1'b0;
        rst_d           = 1'b0;
        sat_d           = 1'b0;

        if ((hold_q == '0) && (pb_v | pc_v)) begin
            if ((pb_v && pb_c == CODE_RST) || (pc_v && pc_c == CODE_RST)) begin
                rst_d      = 1'b1;
                pend_btn_d = 1'b0;
                pend_cmd_d = 1'b0;
                hold_d     = HO_LOAD;
            end else begin
                use_cmd = pc_v & (~pb_v | rr_cmd_q);
                if (pb_v & pc_v) begin
                    rr_cmd_d = ~rr_cmd_q;
                end
                win_c = use_cmd ? pc_c : pb_c;
                if (use_cmd) begin
                    pend_cmd_d = 1'b0;
                end else begin
                    pend_btn_d = 1'b0;
                end
                if (win_c == CODE_UP) begin
                    up_d  = up_ok;
                    sat_d = ~up_ok;
                end else begin
                    down_d = down_ok;
                    sat_d  = ~down_ok;
                end
                if (up_d | down_d) begin
                    hold_d = HO_LOAD;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            cur_q           <= CODE_NOP;
            tmr_q           <= '0;
            pend_btn_q      <= 1'b0;
            pend_btn_code_q <= CODE_NOP;
            pend_cmd_q      <= 1'b0;
            pend_cmd_code_q <= CODE_NOP;
            hold_q          <= '0;
            rr_cmd_q        <= 1'b0;
            cmd_ready       <= 1'b0;
            speed_up        <= 1'b0;
            speed_down      <= 1'b0;
            speed_reset     <= 1'b0;
            sat_drop        <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_q           <= cur_d;
            tmr_q           <= tmr_d;
            pend_btn_q      <= pend_btn_d;
            pend_btn_code_q <= pend_btn_code_d;
            pend_cmd_q      <= pend_cmd_d;
            pend_cmd_code_q <= pend_cmd_code_d;
            hold_q          <= hold_d;
            rr_cmd_q        <= rr_cmd_d;
            cmd_ready       <= ~pend_cmd_d;
            speed_up        <= up_d;
            speed_down      <= down_d;
            speed_reset     <= rst_d;
            sat_drop        <= sat_d;
        end
    end
endmodule

// File: tb/tb_speed_cmd_scheduler.sv
// Bench for speed_cmd_scheduler: cycle model of the scheduling rules plus a divider model,
// directed scenarios with hand-computed pulse timings.
module tb_speed_cmd_scheduler;
    localparam int STEP_T  = 3;
    localparam int MIN_T   = 16;
    localparam int MAX_T   = 100;
    localparam int RD_T    = 10;
    localparam int RR_T    = 4;
    localparam int HO_T    = 2;
    localparam int DEF_DIV = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_up, btn_down, btn_rst;
    logic        cmd_valid;
    logic [1:0]  cmd_code;
    logic        cmd_ready;
    logic [31:0] div_count;
    logic        speed_up, speed_down, speed_reset, sat_drop;

    logic        div_ld;
    logic [31:0] div_ldv;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int q_up[$], q_dn[$], q_rs[$], q_sat[$];

    speed_cmd_scheduler #(
        .STEP(STEP_T), .MIN_DIV(32'd16), .MAX_DIV(32'd100),
        .REPEAT_DELAY(RD_T), .REPEAT_RATE(RR_T), .HOLDOFF(HO_T)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_rst(btn_rst),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(cmd_ready),
        .div_count(div_count),
        .speed_up(speed_up), .speed_down(speed_down), .speed_reset(speed_reset),
        .sat_drop(sat_drop)
    );

    always #5 clk = ~clk;

    // Reference model: outputs expected for the cycle after each edge
    bit         m_init = 0;
    bit         m_act  = 0;
    logic [1:0] m_cur  = 2'b00;
    int         m_held = 0;
    bit         m_pb = 0, m_pc = 0, m_rr_cmd = 0;
    logic [1:0] m_pbc = 2'b00, m_pcc = 2'b00;
    int         m_hold = 0;
    bit         e_up = 0, e_dn = 0, e_rs = 0, e_sat = 0, e_rdy = 0;

    always @(posedge clk) begin : model
        logic [31:0] nd;
        bit          evt, acc, use_cmd, lvl;
        logic [1:0]  ec, win;
        nd = div_count;
        if (e_up) nd = nd - 32'(STEP_T);
        if (e_dn) nd = nd + 32'(STEP_T);
        if (e_rs) nd = 32'(DEF_DIV);
        if (div_ld) nd = div_ldv;
        if (reset) begin
            m_init = 1; m_act = 0; m_pb = 0; m_pc = 0; m_hold = 0; m_rr_cmd = 0;
            e_up = 0; e_dn = 0; e_rs = 0; e_sat = 0; e_rdy = 0;
        end else begin
            evt = 0; ec = 2'b00;
            acc = cmd_valid && e_rdy;
            if (!m_act) begin
                if (btn_rst || btn_up || btn_down) begin
                    m_act = 1; m_held = 0; evt = 1;
                    m_cur = btn_rst ? 2'b11 : (btn_up ? 2'b01 : 2'b10);
                end
            end else begin
                lvl = (m_cur == 2'b11) ? btn_rst : (m_cur == 2'b01) ? btn_up : btn_down;
                if (lvl) begin
                    m_held++;
                    if (m_cur != 2'b11 && m_held >= RD_T && ((m_held - RD_T) % RR_T) == 0) evt = 1;
                end else begin
                    m_act = 0;
                end
            end
            ec = m_cur;
            if (evt && !m_pb) begin m_pb = 1; m_pbc = ec; end
            if (acc && cmd_code != 2'b00) begin m_pc = 1; m_pcc = cmd_code; end
            e_up = 0; e_dn = 0; e_rs = 0; e_sat = 0;
            if (m_hold > 0) begin
                m_hold--;
            end else if (m_pb || m_pc) begin
                if ((m_pb && m_pbc == 2'b11) || (m_pc && m_pcc == 2'b11)) begin
                    e_rs = 1; m_pb = 0; m_pc = 0; m_hold = HO_T;
                end else begin
                    use_cmd = m_pc && (!m_pb || m_rr_cmd);
                    if (m_pb && m_pc) m_rr_cmd = !m_rr_cmd;
                    win = use_cmd ? m_pcc : m_pbc;
                    if (use_cmd) m_pc = 0; else m_pb = 0;
                    if (win == 2'b01) begin
                        if (longint'(div_count) >= MIN_T + STEP_T) begin e_up = 1; m_hold = HO_T; end
                        else e_sat = 1;
                    end else begin
                        if (longint'(div_count) + STEP_T <= MAX_T) begin e_dn = 1; m_hold = HO_T; end
                        else e_sat = 1;
                    end
                end
            end
            e_rdy = !m_pc;
        end
        div_count <= nd;
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Advance one cycle, then compare every output against the model and log pulses
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (m_init) begin
            chk("speed_up",    int'(speed_up),    int'(e_up));
            chk("speed_down",  int'(speed_down),  int'(e_dn));
            chk("speed_reset", int'(speed_reset), int'(e_rs));
            chk("sat_drop",    int'(sat_drop),    int'(e_sat));
            chk("cmd_ready",   int'(cmd_ready),   int'(e_rdy));
        end
        if (speed_up)    q_up.push_back(cyc);
        if (speed_down)  q_dn.push_back(cyc);
        if (speed_reset) q_rs.push_back(cyc);
        if (sat_drop)    q_sat.push_back(cyc);
    endtask

    task automatic chk_pulses(input string nm, input int q[$], input int base, input int t0,
                              input int n, input int exp[8]);
        chk($sformatf("%s_count", nm), q.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < q.size()) chk($sformatf("%s_at%0d", nm, i), q[base + i] - t0, exp[i]);
            else chk($sformatf("%s_at%0d", nm, i), -1, exp[i]);
        end
    endtask

    task automatic load_div(input int v);
        div_ld = 1'b1; div_ldv = 32'(v);
        step();
        div_ld = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) step();
        chk("rst_ready_low", int'(cmd_ready), 0);
        chk("rst_pulses_low", int'(speed_up | speed_down | speed_reset | sat_drop), 0);
        reset = 1'b0;
        step();
        step();
        chk("rst_ready_high", int'(cmd_ready), 1);
    endtask

    initial begin
        int t0, bu, bd, br, bs, acc, guard;
        int acc_cyc[$];
        reset = 1'b1; btn_up = 0; btn_down = 0; btn_rst = 0;
        cmd_valid = 0; cmd_code = 2'b00; div_ld = 0; div_ldv = '0;
        load_div(DEF_DIV);
        do_reset();

        // 1: btn_up held 30 cycles, first repeat after delay then every rate
        load_div(50);
        bu = q_up.size(); bd = q_dn.size(); t0 = cyc;
        btn_up = 1;
        repeat (30) step();
        btn_up = 0;
        repeat (6) step();
        chk_pulses("t1_up", q_up, bu, t0, 6, '{1, 11, 15, 19, 23, 27, 0, 0});
        chk("t1_down_count", q_dn.size() - bd, 0);
        chk("t1_div", int'(div_count), 32);

        // 2: contention with rr at button, then again with rr at command
        do_reset();
        load_div(50);
        bu = q_up.size(); bd = q_dn.size(); t0 = cyc;
        btn_down = 1; cmd_valid = 1; cmd_code = 2'b01;
        step();
        cmd_valid = 0;
        repeat (2) step();
        btn_down = 0;
        repeat (6) step();
        chk_pulses("t2a_down", q_dn, bd, t0, 1, '{1, 0, 0, 0, 0, 0, 0, 0});
        chk_pulses("t2a_up", q_up, bu, t0, 1, '{4, 0, 0, 0, 0, 0, 0, 0});
        bu = q_up.size(); bd = q_dn.size(); t0 = cyc;
        btn_up = 1; cmd_valid = 1; cmd_code = 2'b10;
        step();
        cmd_valid = 0;
        repeat (2) step();
        btn_up = 0;
        repeat (6) step();
        chk_pulses("t2b_down", q_dn, bd, t0, 1, '{1, 0, 0, 0, 0, 0, 0, 0});
        chk_pulses("t2b_up", q_up, bu, t0, 1, '{4, 0, 0, 0, 0, 0, 0, 0});

        // 3: pending down command swallowed by a button reset
        load_div(60);
        bu = q_up.size(); bd = q_dn.size(); br = q_rs.size(); t0 = cyc;
        cmd_valid = 1; cmd_code = 2'b01;
        step();
        cmd_code = 2'b10;
        step();
        cmd_valid = 0; btn_rst = 1;
        step();
        chk("t3_ready_pending", int'(cmd_ready), 0);
        step();
        chk("t3_reset_pulse", int'(speed_reset), 1);
        chk("t3_ready_back", int'(cmd_ready), 1);
        repeat (20) step();
        btn_rst = 0;
        repeat (4) step();
        chk_pulses("t3_reset", q_rs, br, t0, 1, '{4, 0, 0, 0, 0, 0, 0, 0});
        chk_pulses("t3_up", q_up, bu, t0, 1, '{1, 0, 0, 0, 0, 0, 0, 0});
        chk("t3_down_count", q_dn.size() - bd, 0);
        chk("t3_div", int'(div_count), DEF_DIV);

        // 4: saturation limits and their exact boundaries
        load_div(18);
        cmd_valid = 1; cmd_code = 2'b01;
        step();
        cmd_valid = 0;
        chk("t4_sat_low", int'(sat_drop), 1);
        chk("t4_no_up", int'(speed_up), 0);
        step();
        chk("t4_sat_one_cycle", int'(sat_drop), 0);
        load_div(98);
        cmd_valid = 1; cmd_code = 2'b10;
        step();
        cmd_valid = 0;
        chk("t4_sat_high", int'(sat_drop), 1);
        chk("t4_no_down", int'(speed_down), 0);
        step();
        load_div(19);
        cmd_valid = 1; cmd_code = 2'b01;
        step();
        cmd_valid = 0;
        chk("t4_up_at_floor", int'(speed_up), 1);
        repeat (3) step();
        load_div(97);
        cmd_valid = 1; cmd_code = 2'b10;
        step();
        cmd_valid = 0;
        chk("t4_down_at_ceil", int'(speed_down), 1);
        repeat (4) step();
        chk("t4_div", int'(div_count), 100);

        // 5: cmd_valid held for three back-to-back up commands
        load_div(50);
        bu = q_up.size(); t0 = cyc; acc = 0; guard = 0;
        cmd_valid = 1; cmd_code = 2'b01;
        while (acc < 3 && guard < 20) begin
            if (cmd_ready) begin acc++; acc_cyc.push_back(cyc - t0); end
            step();
            guard++;
        end
        cmd_valid = 0;
        chk("t5_accepts", acc, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t5_accept%0d", i), (i < acc_cyc.size()) ? acc_cyc[i] : -1,
                (i == 0) ? 0 : (i == 1) ? 1 : 4);
        end
        repeat (6) step();
        chk_pulses("t5_up", q_up, bu, t0, 3, '{1, 4, 7, 0, 0, 0, 0, 0});

        // 6: reset with button delay, pending command and holdoff all live
        load_div(50);
        bd = q_dn.size(); t0 = cyc;
        btn_down = 1; cmd_valid = 1; cmd_code = 2'b01;
        step();
        chk("t6_down_first", int'(speed_down), 1);
        cmd_valid = 0; reset = 1;
        step();
        chk("t6_rst_ready", int'(cmd_ready), 0);
        chk("t6_rst_quiet", int'(speed_up | speed_down | speed_reset | sat_drop), 0);
        step();
        btn_down = 0; reset = 0;
        bu = q_up.size(); bd = q_dn.size(); br = q_rs.size(); bs = q_sat.size();
        repeat (15) step();
        chk("t6_no_pulses", (q_up.size() - bu) + (q_dn.size() - bd) + (q_rs.size() - br)
                            + (q_sat.size() - bs), 0);
        chk("t6_ready_after", int'(cmd_ready), 1);
        btn_up = 1; reset = 1;
        repeat (2) step();
        reset = 0;
        step();
        chk("t6_held_through_reset", int'(speed_up), 1);
        btn_up = 0;
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
